// File: rtl/dmem_if.sv
// Load/store bus between the core's MEM stage (master) and the data-memory responder (slave).
interface dmem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_amp;
    logic [1:0]  req_lwhb;
    logic        req_uns;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_amp, req_lwhb, req_uns, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_amp, req_lwhb, req_uns, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, fixed LATENCY, byte-enable stores, extended loads.
// Optional misaligned-access trapping is enabled by defining DMEM_MISALIGN_TRAP_EN.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input logic   clk,
    input logic   reset,
    dmem_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    logic [1:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          accept, enter_resp, misalign;

    logic          lat_we, lat_uns;
    logic [AW+1:0] lat_addr;
    logic [31:0]   lat_wdata;
    logic [3:0]    lat_amp;
    logic [1:0]    lat_lwhb;

    logic          cur_we, cur_uns;
    logic [AW+1:0] cur_addr;
    logic [31:0]   cur_wdata;
    logic [3:0]    cur_amp;
    logic [1:0]    cur_lwhb;

    logic [31:0]   word, rdata_d, rdata_q;
    logic [15:0]   half;
    logic [7:0]    byte_val;

    logic [31:0]   mem [DEPTH_WORDS];

    assign accept = (state_q == ST_IDLE) && bus.req_valid;

    // With LATENCY=1 the RESP edge is the accept edge, so the live inputs are used directly.
    assign cur_we    = (state_q == ST_IDLE) ? bus.req_we              : lat_we;
    assign cur_uns   = (state_q == ST_IDLE) ? bus.req_uns             : lat_uns;
    assign cur_addr  = (state_q == ST_IDLE) ? bus.req_addr[AW+1:0]    : lat_addr;
    assign cur_wdata = (state_q == ST_IDLE) ? bus.req_wdata           : lat_wdata;
    assign cur_amp   = (state_q == ST_IDLE) ? bus.req_amp             : lat_amp;
    assign cur_lwhb  = (state_q == ST_IDLE) ? bus.req_lwhb            : lat_lwhb;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    state_d = (LATENCY == 1) ? ST_RESP : ST_BUSY;
                    cnt_d   = CNT_INIT;
                end
            end
            ST_BUSY: begin
                if (cnt_q == 4'd0) state_d = ST_RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            ST_RESP: begin
                if (bus.resp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign enter_resp = (state_q != ST_RESP) && (state_d == ST_RESP);

`ifdef DMEM_MISALIGN_TRAP_EN
    logic is_word, is_half;

    always_comb begin
        if (cur_we) begin
            is_word = (cur_amp == 4'b1111);
            is_half = (cur_amp == 4'b0011) || (cur_amp == 4'b1100);
        end else begin
            is_word = (cur_lwhb == 2'b01) || (cur_lwhb == 2'b00);
            is_half = (cur_lwhb == 2'b10);
        end
        misalign = (is_word && (cur_addr[1:0] != 2'b00)) || (is_half && cur_addr[0]);
    end
`else
    assign misalign = 1'b0;
`endif

    always_comb begin
        word     = mem[cur_addr[AW+1:2]];
        half     = cur_addr[1] ? word[31:16] : word[15:0];
        byte_val = word[{cur_addr[1:0], 3'b000} +: 8];
        case (cur_lwhb)
            2'b10:   rdata_d = cur_uns ? {16'h0, half} : {{16{half[15]}}, half};
            2'b11:   rdata_d = cur_uns ? {24'h0, byte_val} : {{24{byte_val[7]}}, byte_val};
            default: rdata_d = word;
        endcase
        if (cur_we || misalign) rdata_d = 32'h0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            rdata_q   <= 32'h0;
            lat_we    <= 1'b0;
            lat_uns   <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= 32'h0;
            lat_amp   <= 4'h0;
            lat_lwhb  <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (enter_resp) rdata_q <= rdata_d;
            if (accept) begin
                lat_we    <= bus.req_we;
                lat_uns   <= bus.req_uns;
                lat_addr  <= bus.req_addr[AW+1:0];
                lat_wdata <= bus.req_wdata;
                lat_amp   <= bus.req_amp;
                lat_lwhb  <= bus.req_lwhb;
            end
        end
    end

    // RAM is never cleared; a reset held across the RESP edge suppresses the commit.
    always_ff @(posedge clk) begin
        if (!reset && enter_resp && cur_we && !misalign) begin
            for (int i = 0; i < 4; i++) begin
                if (cur_amp[i]) mem[cur_addr[AW+1:2]][8*i +: 8] <= cur_wdata[8*i +: 8];
            end
        end
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    logic err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)           err_q <= 1'b0;
        else if (enter_resp) err_q <= misalign;
    end

    assign bus.resp_err = err_q;
`else
    assign bus.resp_err = 1'b0;
`endif

    assign bus.req_ready  = (state_q == ST_IDLE);
    assign bus.resp_valid = (state_q == ST_RESP);
    assign bus.resp_rdata = rdata_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed steps plus random traffic against a byte-array memory model.
module tb_dmem_responder;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    logic [7:0] mbytes [4096];

    dmem_if bus ();

    dmem_responder #(
        .DEPTH_WORDS(1024),
        .LATENCY    (LAT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Byte-addressed reference: size from amp/lwhb, misaligned if the offset is not a multiple of it.
    task automatic model(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] amp, input logic [1:0] lwhb, input logic uns,
                         output logic [31:0] rd, output logic er);
        int          n;
        int          base;
        logic        mis;
        logic [31:0] v;
        if (we) n = (amp == 4'b1111) ? 4 : ((amp == 4'b0011 || amp == 4'b1100) ? 2 : 1);
        else    n = (lwhb == 2'b10) ? 2 : ((lwhb == 2'b11) ? 1 : 4);
        mis = (int'(a[1:0]) % n) != 0;
`ifdef DMEM_MISALIGN_TRAP_EN
        er = mis;
`else
        er  = 1'b0;
        mis = 1'b0;
`endif
        rd = 32'h0;
        if (mis) return;
        if (we) begin
            for (int i = 0; i < 4; i++)
                if (amp[i]) mbytes[int'(a[11:2]) * 4 + i] = wd[8*i +: 8];
        end else begin
            base = int'(a[11:0]) - (int'(a[1:0]) % n);
            v = 32'h0;
            for (int k = 0; k < n; k++) v = v | (32'(mbytes[base + k]) << (8 * k));
            if (n < 4 && !uns && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
            rd = v;
        end
    endtask

    task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] amp, input logic [1:0] lwhb, input logic uns);
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_wdata = wd;
        bus.req_amp   = amp;
        bus.req_lwhb  = lwhb;
        bus.req_uns   = uns;
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic run(input string tag, input logic we, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] amp, input logic [1:0] lwhb,
                       input logic uns, input int hold, input logic pulse,
                       input logic use_exp, input logic [31:0] exp_rd, input logic exp_er);
        logic [31:0] mrd, rd;
        logic        mer;
        int          lat;
        model(we, a, wd, amp, lwhb, uns, mrd, mer);
        if (use_exp) begin
            mrd = exp_rd;
            mer = exp_er;
        end
        check({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
        drive(we, a, wd, amp, lwhb, uns);
        bus.req_valid  = 1'b1;
        bus.resp_ready = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b0;
        drive(1'($urandom), $urandom, $urandom, 4'($urandom), 2'($urandom), 1'($urandom));
        lat = 0;
        while (!bus.resp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(LAT));
        rd = bus.resp_rdata;
        check({tag, "_rdata"}, bus.resp_rdata, mrd);
        check({tag, "_err"}, 32'(bus.resp_err), 32'(mer));
        for (int h = 0; h < hold; h++) begin
            bus.req_valid = pulse && (h == 1);
            if (pulse && h == 1) drive(1'b1, 32'h8000_0010, 32'hBAD0_BAD0, 4'b1111, 2'b01, 1'b0);
            @(negedge clk);
            check({tag, "_hold_valid"}, 32'(bus.resp_valid), 32'd1);
            check({tag, "_hold_rdata"}, bus.resp_rdata, rd);
            check({tag, "_hold_ready"}, 32'(bus.req_ready), 32'd0);
        end
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        check({tag, "_done_valid"}, 32'(bus.resp_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] r, a, wd, dummy_rd;
        logic [3:0]  amps [8];
        logic        dummy_er;
        int          lat;
        amps = '{4'b1111, 4'b0011, 4'b1100, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 4'h0, 2'b01, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset_req_ready", 32'(bus.req_ready), 32'd1);
        check("reset_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("reset_resp_rdata", bus.resp_rdata, 32'h0);
        check("reset_resp_err", 32'(bus.resp_err), 32'd0);

        // Fill words 0..15 through random aliases so every later load reads defined data.
        for (int w = 0; w < 16; w++) begin
            r = $urandom;
            run("init", 1'b1, {r[31:12], 6'b0, 4'(w), 2'b00}, $urandom, 4'b1111, 2'b01, 1'b0,
                0, 1'b0, 1'b0, 32'h0, 1'b0);
        end

        run("st_beef", 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'b1111, 2'b01, 1'b0, 0, 1'b0,
            1'b1, 32'h0, 1'b0);
        run("ld_word", 1'b0, 32'h8000_0010, 32'h0, 4'h0, 2'b01, 1'b0, 0, 1'b0,
            1'b1, 32'hDEAD_BEEF, 1'b0);
        run("ld_b3_s", 1'b0, 32'h8000_0013, 32'h0, 4'h0, 2'b11, 1'b0, 0, 1'b0,
            1'b1, 32'hFFFF_FFDE, 1'b0);
        run("ld_b3_u", 1'b0, 32'h8000_0013, 32'h0, 4'h0, 2'b11, 1'b1, 0, 1'b0,
            1'b1, 32'h0000_00DE, 1'b0);
        run("ld_h1_s", 1'b0, 32'h8000_0012, 32'h0, 4'h0, 2'b10, 1'b0, 0, 1'b0,
            1'b1, 32'hFFFF_DEAD, 1'b0);
        run("ld_b0_s", 1'b0, 32'h8000_0010, 32'h0, 4'h0, 2'b11, 1'b0, 0, 1'b0,
            1'b1, 32'hFFFF_FFEF, 1'b0);
        run("ld_hold", 1'b0, 32'h8000_0010, 32'h0, 4'h0, 2'b00, 1'b0, 5, 1'b1,
            1'b1, 32'hDEAD_BEEF, 1'b0);
        run("ld_after_pulse", 1'b0, 32'h8000_0010, 32'h0, 4'h0, 2'b01, 1'b0, 0, 1'b0,
            1'b1, 32'hDEAD_BEEF, 1'b0);
        run("st_lane2", 1'b1, 32'h8000_0012, 32'h5555_5555, 4'b0100, 2'b01, 1'b0, 0, 1'b0,
            1'b1, 32'h0, 1'b0);
        run("ld_lane2", 1'b0, 32'h8000_0010, 32'h0, 4'h0, 2'b01, 1'b0, 0, 1'b0,
            1'b1, 32'hDE55_BEEF, 1'b0);

`ifdef DMEM_MISALIGN_TRAP_EN
        run("ld_mis", 1'b0, 32'h8000_0011, 32'h0, 4'h0, 2'b01, 1'b0, 0, 1'b0,
            1'b1, 32'h0, 1'b1);
        run("st_mis", 1'b1, 32'h8000_0011, 32'h0102_0304, 4'b1111, 2'b01, 1'b0, 0, 1'b0,
            1'b1, 32'h0, 1'b1);
        run("ld_after_mis", 1'b0, 32'h8000_0010, 32'h0, 4'h0, 2'b01, 1'b0, 0, 1'b0,
            1'b1, 32'hDE55_BEEF, 1'b0);
`else
        run("ld_mis", 1'b0, 32'h8000_0011, 32'h0, 4'h0, 2'b01, 1'b0, 0, 1'b0,
            1'b1, 32'hDE55_BEEF, 1'b0);
        run("st_mis", 1'b1, 32'h8000_0011, 32'h0102_0304, 4'b1111, 2'b01, 1'b0, 0, 1'b0,
            1'b1, 32'h0, 1'b0);
        run("ld_after_mis", 1'b0, 32'h8000_0010, 32'h0, 4'h0, 2'b01, 1'b0, 0, 1'b0,
            1'b1, 32'h0102_0304, 1'b0);
`endif

        // Reset while a store is in BUSY: the store must be dropped.
        drive(1'b1, 32'h8000_0010, 32'h1234_5678, 4'b1111, 2'b01, 1'b0);
        bus.req_valid = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("rst_busy_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_busy_req_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        run("ld_alias", 1'b0, 32'h8000_1010, 32'h0, 4'h0, 2'b01, 1'b0, 0, 1'b0,
            1'b0, 32'h0, 1'b0);

        // Reset while a store sits in RESP: the store stays committed.
        drive(1'b1, 32'h8000_0014, 32'hCAFE_F00D, 4'b1111, 2'b01, 1'b0);
        model(1'b1, 32'h8000_0014, 32'hCAFE_F00D, 4'b1111, 2'b01, 1'b0, dummy_rd, dummy_er);
        bus.req_valid = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        lat = 0;
        while (!bus.resp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("rst_resp_latency", 32'(lat), 32'(LAT));
        reset = 1'b1;
        #1;
        check("rst_resp_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_resp_req_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        run("ld_committed", 1'b0, 32'h0000_0014, 32'h0, 4'h0, 2'b01, 1'b0, 0, 1'b0,
            1'b1, 32'hCAFE_F00D, 1'b0);

        for (int t = 0; t < 150; t++) begin
            r  = $urandom;
            a  = {r[31:12], 6'b0, 4'($urandom_range(0, 15)), 2'($urandom)};
            wd = $urandom;
            run("rand", 1'($urandom), a, wd, amps[$urandom_range(0, 7)], 2'($urandom),
                1'($urandom), $urandom_range(0, 2), 1'b0, 1'b0, 32'h0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
